// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode, mux and ALU encodings for the controller
package cpu_pkg;
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_NOT    = 2'b11;
  localparam logic [2:0] NSEL_RN    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b100;
endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: splits the instruction register into fields and picks a register number
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  rnum
);
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign sh     = ir[4:3];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign rnum   = ({3{nsel == NSEL_RN}} & ir[10:8])
                | ({3{nsel == NSEL_RD}} & ir[7:5])
                | ({3{nsel == NSEL_RM}} & ir[2:0]);
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore FSM sequencing the 16-bit datapath
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  state_t      state, next;
  logic [15:0] ir;
  logic [2:0]  nsel, rnum, opcode;
  logic [1:0]  op;
  logic        mov_imm, mov_reg, mvn, cmp, need_a;

  instr_decoder u_dec (
    .ir     (ir),
    .nsel   (nsel),
    .opcode (opcode),
    .op     (op),
    .sh     (shift),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .rnum   (rnum)
  );

  assign mov_imm = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign mov_reg = opcode == OPC_MOV && op == OP_MOV_REG;
  assign mvn     = opcode == OPC_ALU && op == OP_MVN;
  assign cmp     = opcode == OPC_ALU && op == OP_CMP;
  assign need_a  = opcode == OPC_ALU && op != OP_MVN;
  // the decoder serves the active port; the idle port falls back to Rn
  assign readnum  = state == S_WRITE_REG ? ir[10:8] : rnum;
  assign writenum = state == S_GET_B ? ir[10:8] : rnum;

  // state and IR; IR only accepts new words while idle so it stays frozen mid-instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && load) ir <= in;
    end
  end

  // next state and Moore control outputs
  always_comb begin
    next  = state;
    nsel  = NSEL_RN;
    w     = 1'b0;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    vsel  = VSEL_C;
    asel  = 1'b0;
    bsel  = 1'b0;
    ALUop = ALU_ADD;
    case (state)
      S_WAIT: begin
        w    = 1'b1;
        next = s ? S_DECODE : S_WAIT;
      end
      S_DECODE:
        next = mov_imm ? S_WRITE_IMM : need_a ? S_GET_A : (mov_reg || mvn) ? S_GET_B : S_WAIT;
      S_WRITE_IMM: begin
        write = 1'b1;
        vsel  = VSEL_IMM8;
        next  = S_WAIT;
      end
      S_GET_A: begin
        loada = 1'b1;
        next  = S_GET_B;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
        next  = S_ALU;
      end
      S_ALU: begin
        asel  = mov_reg || mvn;
        ALUop = mov_reg ? ALU_ADD : op;
        loads = cmp;
        loadc = !cmp;
        next  = cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        write = 1'b1;
        vsel  = VSEL_C;
        next  = S_WAIT;
      end
      default: next = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed vectors with a step-plan model checked every cycle
module tb_cpu_controller;
  localparam int K_WAIT = 0, K_DEC = 1, K_IMM = 2, K_GA = 3, K_GB = 4, K_ALU = 5, K_WR = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic w, write, loada, loadb, loadc, loads, asel;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, shift, aluop;
    logic [15:0] sximm8;
  } snap_t;
  snap_t snaps[$];

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .in(instr), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .vsel(vsel), .asel(asel),
    .bsel(bsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ordered list of steps an instruction walks through after leaving WAIT
  function automatic int plan_at(input logic [15:0] ir, input int i);
    int p[$];
    logic [2:0] opc = ir[15:13];
    logic [1:0] o = ir[12:11];
    p.push_back(K_DEC);
    if (opc == 3'b110 && o == 2'b10) p.push_back(K_IMM);
    else if (opc == 3'b101 && o != 2'b11) begin
      p.push_back(K_GA); p.push_back(K_GB); p.push_back(K_ALU);
      if (o != 2'b01) p.push_back(K_WR);
    end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
      p.push_back(K_GB); p.push_back(K_ALU); p.push_back(K_WR);
    end
    return i < p.size() ? p[i] : K_WAIT;
  endfunction

  function automatic logic [63:0] expect_outs(input int k, input logic [15:0] ir);
    logic ew = 0, ewr = 0, ela = 0, elb = 0, elc = 0, els = 0, eas = 0;
    logic [2:0] ern = ir[10:8], ewn = ir[10:8];
    logic [1:0] evs = 2'b00, eop = 2'b00;
    logic unary = (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) || (ir[15:13] == 3'b101 && ir[12:11] == 2'b11);
    if (k == K_WAIT) ew = 1;
    if (k == K_IMM) begin ewr = 1; evs = 2'b10; end
    if (k == K_GA) ela = 1;
    if (k == K_GB) begin elb = 1; ern = ir[2:0]; end
    if (k == K_ALU) begin
      eas = unary;
      eop = ir[15:13] == 3'b110 ? 2'b00 : ir[12:11];
      if (ir[12:11] == 2'b01 && ir[15:13] == 3'b101) els = 1; else elc = 1;
    end
    if (k == K_WR) begin ewr = 1; ewn = ir[7:5]; end
    return {12'd0, ew, ern, ewn, ewr, ela, elb, elc, els, evs, eas, 1'b0, ir[4:3], eop,
            {{8{ir[7]}}, ir[7:0]}, {{11{ir[4]}}, ir[4:0]}};
  endfunction

  logic [63:0] act_vec;
  assign act_vec = {12'd0, w, readnum, writenum, write, loada, loadb, loadc, loads, vsel,
                    asel, bsel, shift, ALUop, sximm8, sximm5};

  logic [15:0] mir;
  logic        busy;
  int          idx;

  // reference model: IR plus a position inside the instruction's step plan
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mir <= '0; busy <= 1'b0; idx <= 0;
    end else if (!busy) begin
      if (load) mir <= instr;
      if (s) begin busy <= 1'b1; idx <= 0; end
    end else if (plan_at(mir, idx + 1) == K_WAIT) busy <= 1'b0;
    else idx <= idx + 1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) chk("cycle_outputs", act_vec, expect_outs(busy ? plan_at(mir, idx) : K_WAIT, mir));

  function automatic snap_t cur();
    snap_t x;
    x.w = w; x.write = write; x.loada = loada; x.loadb = loadb; x.loadc = loadc;
    x.loads = loads; x.asel = asel; x.readnum = readnum; x.writenum = writenum;
    x.vsel = vsel; x.shift = shift; x.aluop = ALUop; x.sximm8 = sximm8;
    return x;
  endfunction

  // load+start a word, record one snapshot per busy cycle; optional mid-flight load/s pulse
  task automatic run(input logic [15:0] word, input int pulse_at, input logic [15:0] pword, output int cyc);
    @(negedge clk); #1 instr = word; load = 1; s = 1;
    @(negedge clk);
    cyc = 0;
    snaps.delete();
    while (!w && cyc < 20) begin
      snaps.push_back(cur());
      #1;
      if (cyc == pulse_at) begin instr = pword; load = 1; s = 1; end
      else begin load = 0; s = 0; end
      cyc++;
      @(negedge clk);
    end
    #1 load = 0; s = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n;
    repeat (2) @(negedge clk);
    chk("reset_w", w, 1);
    chk("reset_enables", {write, loada, loadb, loadc, loads, asel, bsel}, 0);
    chk("reset_codes", {vsel, shift, ALUop}, 0);
    chk("reset_imm", {sximm8, sximm5}, 0);
    #1 reset_n = 1;

    run(16'hD0FB, -1, 0, cyc);
    chk("movimm_cycles", cyc, 2);
    chk("movimm_write", {snaps[1].write, snaps[1].writenum, snaps[1].vsel}, {1'b1, 3'd0, 2'b10});
    chk("movimm_sximm8", snaps[1].sximm8, 16'hFFFB);

    run(16'hA148, -1, 0, cyc);
    chk("add_cycles", cyc, 5);
    chk("add_get_a", {snaps[1].readnum, snaps[1].loada}, {3'd1, 1'b1});
    chk("add_get_b", {snaps[2].readnum, snaps[2].loadb}, {3'd0, 1'b1});
    chk("add_alu", {snaps[3].shift, snaps[3].aluop, snaps[3].loadc}, {2'b01, 2'b00, 1'b1});
    chk("add_wr", {snaps[4].write, snaps[4].writenum, snaps[4].vsel}, {1'b1, 3'd2, 2'b00});

    run(16'hA900, -1, 0, cyc);
    chk("cmp_cycles", cyc, 4);
    n = 0;
    foreach (snaps[i]) n += snaps[i].write + snaps[i].loadc + (i != 3 ? snaps[i].loads : 0);
    chk("cmp_no_write", n, 0);
    chk("cmp_loads", snaps[3].loads, 1);

    run(16'hB860, -1, 0, cyc);
    chk("mvn_cycles", cyc, 4);
    chk("mvn_skip_a", {snaps[1].loada, snaps[1].loadb}, 2'b01);
    chk("mvn_alu", {snaps[2].asel, snaps[2].aluop}, {1'b1, 2'b11});
    chk("mvn_wr", {snaps[3].write, snaps[3].writenum}, {1'b1, 3'd3});

    run(16'hC0A1, -1, 0, cyc);
    chk("movreg_cycles", cyc, 4);
    chk("movreg_alu", {snaps[2].asel, snaps[2].aluop}, {1'b1, 2'b00});
    run(16'hB022, -1, 0, cyc);
    chk("and_cycles", cyc, 5);

    run(16'hA148, 2, 16'hD105, cyc);
    chk("inflight_cycles", cyc, 5);
    chk("inflight_ir", sximm8, 16'h0048);
    repeat (2) @(negedge clk);
    chk("inflight_no_restart", w, 1);

    run(16'h0000, -1, 0, cyc);
    chk("illegal_cycles", cyc, 1);
    chk("illegal_quiet", {snaps[0].write, snaps[0].loada, snaps[0].loadb, snaps[0].loadc, snaps[0].loads}, 0);

    // s held high re-triggers on every WAIT cycle
    @(negedge clk); #1 instr = 16'hD0FB; load = 1; s = 1;
    n = 0;
    repeat (7) begin @(negedge clk); n += w; end
    #1 load = 0; s = 0;
    chk("hold_s_wait_cycles", n, 2);
    repeat (3) @(negedge clk);

    // reset in GET_B of an ADD
    @(negedge clk); #1 instr = 16'hA148; load = 1; s = 1;
    @(negedge clk); #1 load = 0; s = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_loadb", loadb, 1);
    #2 reset_n = 0;
    #1;
    chk("abort_outputs", {w, loadb, write, readnum, sximm8}, {1'b1, 1'b0, 1'b0, 3'd0, 16'h0000});
    @(negedge clk); #1 reset_n = 1;
    n = 0;
    repeat (6) begin @(negedge clk); n += write + loadc; end
    chk("abort_no_write", n, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
